// File: rtl/serdes_word_aligner.sv
// serdes_word_aligner: finds the bit offset of a sync pattern in the
// deserializer word stream, confirms it on consecutive words, locks, and
// re-frames every accepted word at the locked offset.
module serdes_word_aligner #(
  parameter int NDIVBY     = 8,
  parameter int WOFF       = 4,
  parameter int LOCK_COUNT = 4
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [2*NDIVBY-1:0]   in_data,
  input  logic [2*NDIVBY-1:0]   config_pattern,
  input  logic                  config_enable,
  output logic                  out_valid,
  output logic [2*NDIVBY-1:0]   out_data,
  output logic                  locked,
  output logic [WOFF-1:0]       offset
);

  localparam int W  = 2 * NDIVBY;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t            state_r;
  logic [W-1:0]      prev_r;
  logic              prev_full_r;
  logic [CW-1:0]     count_r;

  logic [2*W-1:0]    window_s;
  logic [W-1:0]      cand_s [W];
  logic [W-1:0]      match_s;
  logic [W-1:0]      sel_cand_s;
  logic [WOFF-1:0]   first_s;
  logic              any_s;
  logic              advance_s;
  logic [CW-1:0]     count_inc_s;

  assign window_s  = {in_data, prev_r};
  assign advance_s = in_valid & prev_full_r;

  // Every bit offset of the two-word window is a candidate word.
  for (genvar k = 0; k < W; k++) begin : g_cand
    assign cand_s[k]  = window_s[k +: W];
    assign match_s[k] = (cand_s[k] == config_pattern);
  end

  assign sel_cand_s = cand_s[offset];

  // Lowest matching offset wins when the pattern matches several offsets.
  always_comb begin
    first_s = {WOFF{1'b0}};
    any_s   = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      if (match_s[k]) begin
        first_s = WOFF'(k);
        any_s   = 1'b1;
      end else begin
        first_s = first_s;
        any_s   = any_s;
      end
    end
  end

  // Saturating increment so the match counter never wraps.
  always_comb begin
    if (count_r != COUNT_MAX) begin
      count_inc_s = count_r + COUNT_ONE;
    end else begin
      count_inc_s = count_r;
    end
  end

  // History word and re-framed output register, active in every state.
  always_ff @(posedge clks) begin
    if (reset) begin
      prev_r      <= {W{1'b0}};
      prev_full_r <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= {W{1'b0}};
    end else begin
      if (in_valid) begin
        prev_r      <= in_data;
        prev_full_r <= 1'b1;
      end
      if (advance_s) begin
        out_data  <= sel_cand_s;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Alignment FSM: search, confirm on consecutive words, then lock.
  always_ff @(posedge clks) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CW{1'b0}};
      locked  <= 1'b0;
      offset  <= {WOFF{1'b0}};
    end else if (!config_enable) begin
      // Disable wins over any simultaneous match; offset is kept.
      state_r <= ST_IDLE;
      count_r <= {CW{1'b0}};
      locked  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_SEARCH;
          count_r <= {CW{1'b0}};
          locked  <= 1'b0;
        end
        ST_SEARCH: begin
          if (advance_s && any_s) begin
            offset  <= first_s;
            count_r <= COUNT_ONE;
            if (LOCK_COUNT == 1) begin
              state_r <= ST_LOCKED;
              locked  <= 1'b1;
            end else begin
              state_r <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (advance_s) begin
            if (sel_cand_s == config_pattern) begin
              count_r <= count_inc_s;
              if (count_inc_s == COUNT_MAX) begin
                state_r <= ST_LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              // The failing word is not searched again.
              state_r <= ST_SEARCH;
              count_r <= {CW{1'b0}};
            end
          end
        end
        ST_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= {CW{1'b0}};
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Self-checking bench for serdes_word_aligner: directed scenarios plus
// randomized traffic, all compared to a behavioural model of the aligner.
module tb_serdes_word_aligner;

  localparam int NDIVBY = 8;
  localparam int WOFF   = 4;
  localparam int LC     = 4;
  localparam int W      = 16;

  logic          clks;
  logic          reset;
  logic          in_valid;
  logic [15:0]   in_data;
  logic [15:0]   config_pattern;
  logic          config_enable;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          locked;
  logic [3:0]    offset;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: mode 0=idle 1=searching 2=confirming 3=locked
  int          m_mode;
  int          m_count;
  logic [15:0] m_prev;
  logic        m_prev_full;
  logic        m_out_valid;
  logic [15:0] m_out_data;
  logic        m_locked;
  logic [3:0]  m_offset;

  serdes_word_aligner #(.NDIVBY(NDIVBY), .WOFF(WOFF), .LOCK_COUNT(LC)) dut (
    .clks(clks), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .config_pattern(config_pattern), .config_enable(config_enable),
    .out_valid(out_valid), .out_data(out_data), .locked(locked), .offset(offset)
  );

  initial clks = 1'b0;
  always #5 clks = ~clks;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int s);
    logic [31:0] t;
    t = {x, x} << s;
    return t[31:16];
  endfunction

  function automatic logic [15:0] cand_of(input logic [15:0] newer, input logic [15:0] older, input int k);
    logic [31:0] w;
    w = {newer, older} >> k;
    return w[15:0];
  endfunction

  // Behavioural reference: one clock edge worth of the aligner rules.
  task automatic model_tick(input logic r, input logic v, input logic [15:0] d,
                            input logic [15:0] pat, input logic en);
    int low;
    logic adv;
    if (r) begin
      m_mode = 0; m_count = 0; m_prev = 16'h0; m_prev_full = 1'b0;
      m_out_valid = 1'b0; m_out_data = 16'h0; m_locked = 1'b0; m_offset = 4'd0;
    end else begin
      adv = v && m_prev_full;
      low = -1;
      for (int k = W - 1; k >= 0; k--)
        if (cand_of(d, m_prev, k) == pat) low = k;
      if (adv) begin
        m_out_valid = 1'b1;
        m_out_data  = cand_of(d, m_prev, int'(m_offset));
      end else begin
        m_out_valid = 1'b0;
      end
      if (!en) begin
        m_mode = 0; m_count = 0; m_locked = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1 && adv && low >= 0) begin
        m_offset = 4'(low);
        m_count  = 1;
        if (LC == 1) begin m_mode = 3; m_locked = 1'b1; end
        else m_mode = 2;
      end else if (m_mode == 2 && adv) begin
        if (cand_of(d, m_prev, int'(m_offset)) == pat) begin
          m_count = m_count + 1;
          if (m_count == LC) begin m_mode = 3; m_locked = 1'b1; end
        end else begin
          m_mode = 1; m_count = 0;
        end
      end
      if (v) begin
        m_prev = d; m_prev_full = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, settle.
  task automatic step(input logic r, input logic v, input logic [15:0] d, input logic en);
    reset = r; in_valid = v; in_data = d; config_enable = en;
    @(posedge clks);
    model_tick(r, v, d, config_pattern, en);
    #1;
  endtask

  task automatic idle_gap(input int maxg, input logic en);
    int g;
    g = $urandom_range(0, maxg);
    for (int i = 0; i < g; i++) step(1'b0, 1'b0, 16'($urandom), en);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'(i), 16'($urandom), 1'b1);
      n_checks++;
      if ({out_valid, out_data, locked, offset} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got v=%0b d=%h l=%0b o=%0d want all zero",
                 i, out_valid, out_data, locked, offset);
      end
    end
  endtask

  task automatic test_clean_lock;
    logic [15:0] d;
    config_pattern = 16'hA5C3;
    d = {config_pattern[10:0], config_pattern[15:11]};
    step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      idle_gap(2, 1'b1);
      step(1'b0, 1'b1, d, 1'b1);
      n_checks++;
      if ({out_valid, out_data, locked, offset} !== {m_out_valid, m_out_data, m_locked, m_offset}) begin
        n_fail++;
        $display("FAIL clean_lock word%0d: got %h/%h/%0b/%0d want %h/%h/%0b/%0d", n,
                 out_valid, out_data, locked, offset, m_out_valid, m_out_data, m_locked, m_offset);
      end
      if (n == 2) begin
        n_checks++;
        if (offset !== 4'd5) begin n_fail++; $display("FAIL clean_offset: got %0d want 5", offset); end
      end
      if (n == 4 || n == 5) begin
        n_checks++;
        if (locked !== (n == 5)) begin
          n_fail++; $display("FAIL clean_locked word%0d: got %0b want %0b", n, locked, n == 5);
        end
      end
      if (n >= 3) begin
        n_checks++;
        if (out_data !== 16'hA5C3) begin n_fail++; $display("FAIL clean_data: got %h want a5c3", out_data); end
      end
    end
  endtask

  task automatic test_verify_fail;
    logic [15:0] d;
    config_pattern = 16'hA5C3;
    d = {config_pattern[10:0], config_pattern[15:11]};
    step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      idle_gap(1, 1'b1);
      step(1'b0, 1'b1, (n == 4) ? (d ^ 16'h0001) : d, 1'b1);
      n_checks++;
      if ({out_valid, out_data, locked, offset} !== {m_out_valid, m_out_data, m_locked, m_offset}) begin
        n_fail++;
        $display("FAIL verify_fail word%0d: got %h/%h/%0b/%0d want %h/%h/%0b/%0d", n,
                 out_valid, out_data, locked, offset, m_out_valid, m_out_data, m_locked, m_offset);
      end
      n_checks++;
      if (locked !== (n == 8)) begin
        n_fail++; $display("FAIL verify_locked word%0d: got %0b want %0b", n, locked, n == 8);
      end
    end
    n_checks++;
    if (offset !== 4'd5) begin n_fail++; $display("FAIL verify_offset: got %0d want 5", offset); end
  endtask

  task automatic test_multi_match;
    config_pattern = 16'h0000;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      step(1'b0, 1'b1, 16'h0000, 1'b1);
      n_checks++;
      if ({locked, offset} !== {1'(n >= 5), 4'd0}) begin
        n_fail++; $display("FAIL multi_match word%0d: got l=%0b o=%0d want l=%0b o=0", n, locked, offset, n >= 5);
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [15:0] d;
    config_pattern = 16'hA5C3;
    d = {config_pattern[10:0], config_pattern[15:11]};
    step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int n = 1; n <= 5; n++) step(1'b0, 1'b1, d, 1'b1);
    step(1'b0, 1'b1, d, 1'b0);
    n_checks++;
    if ({out_valid, locked, offset} !== {1'b1, 1'b0, 4'd5}) begin
      n_fail++; $display("FAIL enable_drop: got v=%0b l=%0b o=%0d want v=1 l=0 o=5", out_valid, locked, offset);
    end
    for (int n = 1; n <= 6; n++) begin
      step(1'b0, 1'b1, d, 1'b1);
      n_checks++;
      if ({out_valid, out_data, locked, offset} !== {m_out_valid, m_out_data, m_locked, m_offset}) begin
        n_fail++;
        $display("FAIL enable_relock cyc%0d: got %h/%h/%0b/%0d want %h/%h/%0b/%0d", n,
                 out_valid, out_data, locked, offset, m_out_valid, m_out_data, m_locked, m_offset);
      end
    end
    n_checks++;
    if ({locked, offset} !== {1'b1, 4'd5}) begin
      n_fail++; $display("FAIL enable_relock_final: got l=%0b o=%0d want l=1 o=5", locked, offset);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    config_pattern = 16'hA5C3;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      step(1'b0, 1'b1, config_pattern, 1'b1);
      n_checks++;
      if (out_valid !== (n >= 2)) begin
        n_fail++; $display("FAIL b2b_valid word%0d: got %0b want %0b", n, out_valid, n >= 2);
      end
    end
    n_checks++;
    if ({locked, offset, out_data} !== {1'b1, 4'd0, 16'hA5C3}) begin
      n_fail++; $display("FAIL zero_skew: got l=%0b o=%0d d=%h want l=1 o=0 d=a5c3", locked, offset, out_data);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    d = {config_pattern[0], config_pattern[15:1]};
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 1'b1, d, 1'b1);
      n_checks++;
      if ({out_valid, out_data, locked, offset} !== {m_out_valid, m_out_data, m_locked, m_offset}) begin
        n_fail++;
        $display("FAIL wrap cyc%0d: got %h/%h/%0b/%0d want %h/%h/%0b/%0d", n,
                 out_valid, out_data, locked, offset, m_out_valid, m_out_data, m_locked, m_offset);
      end
    end
    n_checks++;
    if ({locked, offset, out_data} !== {1'b1, 4'd15, 16'hA5C3}) begin
      n_fail++; $display("FAIL wrap_final: got l=%0b o=%0d d=%h want l=1 o=15 d=a5c3", locked, offset, out_data);
    end
  endtask

  task automatic test_random;
    int skew;
    logic r, v, en;
    logic [15:0] d;
    for (int round = 0; round < 4; round++) begin
      config_pattern = 16'($urandom);
      skew = $urandom_range(0, 15);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      for (int c = 0; c < 300; c++) begin
        r  = ($urandom_range(0, 149) == 0);
        v  = 1'($urandom_range(0, 1));
        en = ($urandom_range(0, 24) != 0);
        d  = ($urandom_range(0, 9) < 8) ? rotl16(config_pattern, skew) : 16'($urandom);
        step(r, v, d, en);
        n_checks++;
        if ({out_valid, out_data, locked, offset} !== {m_out_valid, m_out_data, m_locked, m_offset}) begin
          n_fail++;
          $display("FAIL random r%0d c%0d: got %h/%h/%0b/%0d want %h/%h/%0b/%0d", round, c,
                   out_valid, out_data, locked, offset, m_out_valid, m_out_data, m_locked, m_offset);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0;
    config_pattern = 16'hA5C3; config_enable = 1'b0;
    test_reset();
    test_clean_lock();
    test_verify_fail();
    test_multi_match();
    test_enable_drop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serdes_word_aligner.md
# serdes_word_aligner

Receive-side word aligner between the deserializer's parallel output and the link layer. It takes one 2*NDIVBY-bit word per slow-word strobe. During training it searches every bit offset for a configured sync pattern, then confirms the pattern on consecutive words and locks. Once locked it emits every subsequent word re-framed at the locked offset. It removes the arbitrary bit skew between the serializer's word boundary and the deserializer's word boundary.

## Interface
- NDIVBY, 8, bit pairs per word; word width W = 2*NDIVBY
- WOFF, 4, offset width, log2(W)
- LOCK_COUNT, 4, consecutive matching words required to lock (>= 1)
- clks  in  1  clock (fast serdes clock)
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_data valid this cycle; may pulse on any cycle, including back-to-back
- in_data  in  W  received word; bit 0 is the earliest received bit
- config_pattern  in  W  sync word, bit 0 transmitted first
- config_enable  in  1  1 = run alignment; 0 = hold in IDLE
- out_valid  out  1  out_data valid, one-cycle pulse
- out_data  out  W  re-framed word, bit 0 earliest
- locked  out  1  alignment locked
- offset  out  WOFF  current bit offset k, 0..W-1

## Operation
- Window: prev holds the last accepted word, and prev_full flags that prev is valid. On in_valid, window = {in_data, prev} (2W bits, prev in the low half). Candidate k = window[k+W-1:k] for k = 0..W-1. After the update, prev <= in_data and prev_full <= 1.
- Output path: on in_valid with prev_full=1, the block registers out_data <= candidate[offset] and out_valid <= 1. This happens in every state. Otherwise out_valid <= 0 and out_data holds its value.
- The FSM advances only on in_valid with prev_full=1. It has the following states:
  - IDLE: locked=0, match counter cleared. Transitions to SEARCH on the first cycle with config_enable=1.
  - SEARCH: all W candidates are compared to config_pattern in parallel.
    - If any match, offset <= lowest matching k and count <= 1. The next state is LOCKED if LOCK_COUNT==1, otherwise VERIFY.
    - No match: remain in SEARCH; offset unchanged.
  - VERIFY: only candidate[offset] is compared.
    - Match: count <= count+1. When count+1 == LOCK_COUNT, the next state is LOCKED.
    - Mismatch: go to SEARCH, count <= 0. That same word is not re-searched.
  - LOCKED: locked=1, offset frozen. The FSM does not check payload and has no automatic unlock.
- config_enable=0 in any state: the next state is IDLE, locked <= 0 and count <= 0. offset, prev and prev_full are retained.
- Counter width is clog2(LOCK_COUNT+1) and it saturates; it never wraps.
- Pattern matching multiple offsets (e.g. all-zero pattern or a periodic pattern): the lowest k wins.
- The offset written in SEARCH applies to out_data starting with the next accepted word.

## Timing
- Reset values: out_valid=0, out_data=0, locked=0, offset=0, state=IDLE, prev=0, prev_full=0, count=0.
- Output latency: 1 cycle. out_valid/out_data are registered in the cycle after in_valid.
- locked rises 1 cycle after the in_valid carrying the LOCK_COUNT-th consecutive match.
- The first in_valid after reset only fills prev: no out_valid and no FSM action.
- config_enable is sampled every clks cycle, independent of in_valid. Deassertion takes priority over a simultaneous match.
- Reset mid-VERIFY or mid-LOCKED returns to reset values on the next edge. The word in flight is dropped.
- No internal word-rate assumption: there is no handshake back-pressure, and every in_valid is consumed.

## Test plan
- Reset: assert reset 2 cycles with in_valid toggling -> all outputs 0, state IDLE, no out_valid.
- Clean lock: P=16'hA5C3, enable=1, stream in_data={P[10:0],P[15:11]} on every in_valid -> offset=5 after the 2nd word; locked=1 one cycle after the 5th word (LOCK_COUNT=4, first word only fills prev); subsequent out_data=16'hA5C3.
- Verify failure: as above, but corrupt the 3rd matching word -> state returns to SEARCH and locked stays 0. Lock is re-acquired after 4 further clean matches with offset=5.
- Multiple matches: P=16'h0000, all-zero input -> offset=0, locked after 4 matches.
- Enable drop: lock at offset 5, then deassert config_enable for 1 cycle -> locked=0 next cycle, offset still 5, out_valid continues. Reassert -> SEARCH, re-lock.
- Zero skew / wrap: in_data=P directly -> offset=0. Shift skew to 15 (in_data={P[0],P[15:1]}) -> offset=15 after re-enable. Back-to-back in_valid every cycle -> out_valid every cycle, 1-cycle latency.
